// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_pkg                                                      |
// | Description : Shared AES widths, byte-array state type and engine FSM enum |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    // Element [AES_BYTES-1] sits in the top bits, so it carries byte 0 of the state.
    typedef logic [AES_BYTES-1:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } aes_fsm_t;

endpackage
`default_nettype wire

// File: rtl/inverse_substitution_box.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inverse_substitution_box                                     |
// | Description : Combinational AES inverse S-box, one byte in, one byte out   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inverse_substitution_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 occupies the most significant byte; one row of the table per line.
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [7:0] w_slot;

    assign w_slot   = ~in_byte;
    assign out_byte = c_inv_sbox[{w_slot, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inv_sub_bytes_seq                                            |
// | Description : Iterative AES InvSubBytes, LANES bytes substituted per clock |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_state,
    output logic                   busy
);

    localparam int               N_BEATS     = AES_BYTES / LANES;
    localparam int               CNT_W       = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(N_BEATS - 1);

    aes_fsm_t         r_fsm;
    aes_fsm_t         w_fsm_nxt;
    logic [CNT_W-1:0] r_cnt;
    aes_state_t       r_data;
    logic             w_last;
    logic [3:0]       w_pos      [LANES];
    logic [7:0]       w_lane_in  [LANES];
    logic [7:0]       w_lane_out [LANES];

    assign w_last    = (r_cnt == c_last_beat);
    assign out_state = r_data;

    // Lane g of beat cnt handles byte cnt*LANES+g; byte 0 lives in the top element.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_pos[g]     = 4'(AES_BYTES - 1 - (int'(r_cnt) * LANES + g));
        assign w_lane_in[g] = r_data[w_pos[g]];

        inverse_substitution_box u_isbox (
            .in_byte  (w_lane_in[g]),
            .out_byte (w_lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = SUB;
            end
            SUB: begin
                busy = 1'b1;
                if (w_last) w_fsm_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
        if (abort) w_fsm_nxt = IDLE;
    end

    // The counter parks on the last beat in DONE and is only cleared on a new load or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (r_fsm == IDLE && in_valid) begin
            r_data <= in_state;
            r_cnt  <= '0;
        end else if (r_fsm == SUB) begin
            for (int l = 0; l < LANES; l++) begin
                r_data[w_pos[l]] <= w_lane_out[l];
            end
            if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
